ms_slave_sequencer: RTL and testbench

- Parametrised master/slave phase sequencer for the generated-RTL test suite.
- Each pass samples a shared input and polls NUM_CH slave-in channels in fixed order, each gated by its sync flag.
- Accumulates the accepted channel values onto the sampled shared input, then publishes the result on a shared output together with a success flag.
- Adds a per-channel wait timeout and an accept acknowledge.

---
 rtl/ms_slave_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ms_slave_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ms_slave_sequencer.sv
// ms_slave_sequencer: master/slave phase sequencer.
//
// Each pass runs three phases:
//   SECTION_A  samples sh_in into the accumulator.
//   SECTION_B  polls NUM_CH slave channels in order. A channel whose sync is high is accepted and
//              added to the accumulator. A channel that stays idle for TIMEOUT cycles is skipped.
//   SECTION_C  publishes the accumulator on sh_out, and publishes succ.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   s_in       slave data, channel i at [i*DATA_W +: DATA_W]
//   s_in_sync  per-channel data-valid level
//   s_in_ack   per-channel accept strobe (combinational)
//   sh_in      shared input, sampled in SECTION_A only
//   sh_out     shared output (registered)
//   succ       high after a pass in which every channel was accepted
//   phase      current phase: 0=SECTION_A, 1=SECTION_B, 2=SECTION_C
//   cur_ch     channel being polled
//
// Optional build macro MS_SEQ_SATURATE_EN: when it is defined, each accumulate step saturates to the
// signed limits. When it is undefined, each accumulate step wraps modulo 2^DATA_W.
module ms_slave_sequencer #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 8,
  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   s_in,
  input  logic [NUM_CH-1:0]          s_in_sync,
  output logic [NUM_CH-1:0]          s_in_ack,
  input  logic [DATA_W-1:0]          sh_in,
  output logic [DATA_W-1:0]          sh_out,
  output logic                       succ,
  output logic [1:0]                 phase,
  output logic [ChW-1:0]             cur_ch
);

  // The wait counter only ever holds 0..TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ChW-1:0]  LastCh   = ChW'(NUM_CH - 1);
  localparam logic [CntW-1:0] LastWait = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StSectionA = 2'd0,
    StSectionB = 2'd1,
    StSectionC = 2'd2
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [ChW-1:0]      cur_ch_q, cur_ch_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
  logic                all_ok_q, all_ok_d;
  logic [DATA_W-1:0]   sh_out_q, sh_out_d;
  logic                succ_q, succ_d;

  logic [DATA_W-1:0]   sel_data;
  logic                sel_sync;
  logic [DATA_W-1:0]   sum_wrap;
  logic [DATA_W-1:0]   sum;
  logic                advance;

  // Select the data and sync bit of the polled channel.
  always_comb begin
    sel_data = '0;
    sel_sync = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_ch_q == ChW'(i)) begin
        sel_data = s_in[i*DATA_W +: DATA_W];
        sel_sync = s_in_sync[i];
      end
    end
  end

  // Only the polled channel can be acknowledged, and only in SECTION_B.
  always_comb begin
    s_in_ack = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      s_in_ack[i] = (phase_q == StSectionB) && (cur_ch_q == ChW'(i)) && s_in_sync[i];
    end
  end

  assign sum_wrap = val_q + sel_data;

`ifdef MS_SEQ_SATURATE_EN
  logic pos_ovf, neg_ovf;
  // Signed overflow happens only when both operands have the same sign and the sign of the sum
  // differs from it.
  assign pos_ovf = ~val_q[DATA_W-1] & ~sel_data[DATA_W-1] &  sum_wrap[DATA_W-1];
  assign neg_ovf =  val_q[DATA_W-1] &  sel_data[DATA_W-1] & ~sum_wrap[DATA_W-1];
  always_comb begin
    if (pos_ovf) begin
      sum = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (neg_ovf) begin
      sum = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sum = sum_wrap;
    end
  end
`else
  assign sum = sum_wrap;
`endif

  always_comb begin
    phase_d    = phase_q;
    cur_ch_d   = cur_ch_q;
    val_d      = val_q;
    wait_cnt_d = wait_cnt_q;
    all_ok_d   = all_ok_q;
    sh_out_d   = sh_out_q;
    succ_d     = succ_q;
    advance    = 1'b0;

    unique case (phase_q)
      StSectionA: begin
        val_d      = sh_in;
        cur_ch_d   = '0;
        wait_cnt_d = '0;
        all_ok_d   = 1'b1;
        phase_d    = StSectionB;
      end
      StSectionB: begin
        // A sync takes priority over the timeout, so a sync that arrives on the last wait cycle is
        // still accepted.
        if (sel_sync) begin
          val_d      = sum;
          wait_cnt_d = '0;
          advance    = 1'b1;
        end else if (wait_cnt_q == LastWait) begin
          all_ok_d   = 1'b0;
          wait_cnt_d = '0;
          advance    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
        if (advance) begin
          if (cur_ch_q == LastCh) begin
            phase_d = StSectionC;
          end else begin
            cur_ch_d = cur_ch_q + ChW'(1);
          end
        end
      end
      StSectionC: begin
        sh_out_d = val_q;
        succ_d   = all_ok_q;
        phase_d  = StSectionA;
      end
      default: begin
        phase_d = StSectionA;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= StSectionA;
      cur_ch_q   <= '0;
      val_q      <= '0;
      wait_cnt_q <= '0;
      all_ok_q   <= 1'b1;
      sh_out_q   <= '0;
      succ_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cur_ch_q   <= cur_ch_d;
      val_q      <= val_d;
      wait_cnt_q <= wait_cnt_d;
      all_ok_q   <= all_ok_d;
      sh_out_q   <= sh_out_d;
      succ_q     <= succ_d;
    end
  end

  assign sh_out = sh_out_q;
  assign succ   = succ_q;
  assign phase  = phase_q;
  assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_ms_slave_sequencer.sv
// Bench for ms_slave_sequencer with NUM_CH=2, DATA_W=32 and TIMEOUT=4.
//
// The stimulus drives one cycle per call, at each falling edge. It also pushes the expected acks
// and the expected pass results into queues. A monitor samples the outputs 2 time units after
// each falling edge. It pops and compares whenever an ack is high, and whenever a pass has just
// finished SECTION_C.
module tb_ms_slave_sequencer;

  localparam int unsigned NumCh   = 2;
  localparam int unsigned DataW   = 32;
  localparam int unsigned Timeout = 4;

  logic               clk;
  logic               rst;
  logic [DataW-1:0]   d0, d1;
  logic [NumCh-1:0]   s_in_sync;
  logic [NumCh-1:0]   s_in_ack;
  logic [DataW-1:0]   sh_in;
  logic [DataW-1:0]   sh_out;
  logic               succ;
  logic [1:0]         phase;
  logic [0:0]         cur_ch;

  int n_cmp = 0;
  int n_err = 0;

  logic [NumCh-1:0] exp_ack[$];
  logic [DataW-1:0] exp_sh[$];
  logic             exp_succ[$];

  ms_slave_sequencer #(
    .NUM_CH (NumCh),
    .DATA_W (DataW),
    .TIMEOUT(Timeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_in     ({d1, d0}),
    .s_in_sync(s_in_sync),
    .s_in_ack (s_in_ack),
    .sh_in    (sh_in),
    .sh_out   (sh_out),
    .succ     (succ),
    .phase    (phase),
    .cur_ch   (cur_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic cyc(input logic r, input logic [31:0] sh, input logic [1:0] sy,
                     input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst       = r;
    sh_in     = sh;
    s_in_sync = sy;
    d0        = a;
    d1        = b;
  endtask

  task automatic push_res(input logic [31:0] v, input logic ok);
    exp_sh.push_back(v);
    exp_succ.push_back(ok);
  endtask

  // Full-sync pass: A, B(ch0), B(ch1), C.
  task automatic sync_pass(input logic [31:0] sh, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res);
    exp_ack.push_back(2'b01);
    exp_ack.push_back(2'b10);
    push_res(res, 1'b1);
    repeat (4) cyc(1'b0, sh, 2'b11, a, b);
  endtask

  // Monitor
  initial begin
    logic [1:0] prev_phase;
    prev_phase = 2'd0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("ack_in_reset", {30'd0, s_in_ack}, 32'd0);
        prev_phase = 2'd0;
      end else begin
        if (s_in_ack != '0) begin
          if (exp_ack.size() == 0) chk("ack_unexpected", {30'd0, s_in_ack}, 32'd0);
          else chk("ack", {30'd0, s_in_ack}, {30'd0, exp_ack.pop_front()});
        end
        if (prev_phase == 2'd2) begin
          if (exp_sh.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_unexpected: got sh_out 0x%0h succ %0b, expected none",
                     sh_out, succ);
          end else begin
            chk("sh_out", sh_out, exp_sh.pop_front());
            chk("succ", {31'd0, succ}, {31'd0, exp_succ.pop_front()});
          end
        end
        prev_phase = phase;
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] ovf_exp;
`ifdef MS_SEQ_SATURATE_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'h8000_0000;
`endif
    rst = 1'b1; sh_in = '0; s_in_sync = '0; d0 = '0; d1 = '0;
    // The inputs are held active during reset and must be ignored.
    repeat (3) cyc(1'b1, 32'd55, 2'b11, 32'd9, 32'd9);
    #2;
    chk("rst_phase", {30'd0, phase}, 32'd0);
    chk("rst_cur_ch", {31'd0, cur_ch}, 32'd0);
    chk("rst_sh_out", sh_out, 32'd0);
    chk("rst_succ", {31'd0, succ}, 32'd0);

    // Basic pass, twice, back to back.
    sync_pass(32'd10, 32'd5, 32'd7, 32'd22);
    sync_pass(32'd10, 32'd5, 32'd7, 32'd22);

    // Timeout on ch1. While ch1 waits, the sync on ch0 stays high and must draw no ack.
    exp_ack.push_back(2'b01);
    push_res(32'd15, 1'b0);
    repeat (7) cyc(1'b0, 32'd10, 2'b01, 32'd5, 32'd0);

    // Late sync: ch1 is accepted on its 4th wait cycle.
    exp_ack.push_back(2'b01);
    exp_ack.push_back(2'b10);
    push_res(32'd4, 1'b1);
    cyc(1'b0, 32'd0, 2'b00, 32'd1, 32'd3);
    cyc(1'b0, 32'd0, 2'b01, 32'd1, 32'd3);
    repeat (3) cyc(1'b0, 32'd0, 2'b00, 32'd1, 32'd3);
    cyc(1'b0, 32'd0, 2'b10, 32'd1, 32'd3);
    cyc(1'b0, 32'd0, 2'b00, 32'd1, 32'd3);

    // Overflow.
    sync_pass(32'h7FFF_FFFF, 32'd1, 32'd0, ovf_exp);

    // sh_in changes after SECTION_A and must be ignored until the next pass.
    exp_ack.push_back(2'b01);
    exp_ack.push_back(2'b10);
    push_res(32'd22, 1'b1);
    cyc(1'b0, 32'd10, 2'b11, 32'd5, 32'd7);
    repeat (3) cyc(1'b0, 32'd99, 2'b11, 32'd5, 32'd7);
    sync_pass(32'd99, 32'd5, 32'd7, 32'd111);

    // Mid-pass reset while ch1 is being polled.
    exp_ack.push_back(2'b01);
    cyc(1'b0, 32'd50, 2'b11, 32'd5, 32'd7);
    cyc(1'b0, 32'd50, 2'b01, 32'd5, 32'd7);
    cyc(1'b0, 32'd50, 2'b01, 32'd5, 32'd7);
    #2;
    chk("mid_phase", {30'd0, phase}, 32'd1);
    chk("mid_cur_ch", {31'd0, cur_ch}, 32'd1);
    cyc(1'b1, 32'd50, 2'b11, 32'd5, 32'd7);
    #2;
    chk("mrst_phase", {30'd0, phase}, 32'd0);
    chk("mrst_cur_ch", {31'd0, cur_ch}, 32'd0);
    chk("mrst_sh_out", sh_out, 32'd0);
    chk("mrst_succ", {31'd0, succ}, 32'd0);
    chk("mrst_ack", {30'd0, s_in_ack}, 32'd0);
    cyc(1'b1, 32'd50, 2'b11, 32'd5, 32'd7);
    sync_pass(32'd2, 32'd5, 32'd7, 32'd14);

    // Let the monitor drain the final result.
    repeat (2) cyc(1'b0, 32'd0, 2'b00, 32'd0, 32'd0);
    #3;
    chk("ack_queue_left", exp_ack.size(), 32'd0);
    chk("result_queue_left", exp_sh.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
